// File: rtl/bus_collect.sv
// Serial frame collector: start bit, WIDTH data bits LSB first, optional even parity, stop bit.
// Holds the last received word with valid/error/overrun flags until acknowledged.
module bus_collect #(
  parameter int unsigned WIDTH     = 5,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i,
  input  logic             ack,
  output logic [WIDTH-1:0] word,
  output logic             valid,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             par_bit;
  logic             last_bit_c;

  assign last_bit_c = (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i) state_nxt = DATA;
      DATA:    if (last_bit_c) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  state_nxt = STOP;
      STOP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Shift register, bit counter and held-word outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      word       <= '0;
      valid      <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      busy <= (state_nxt != IDLE);
      case (state)
        IDLE: cnt <= '0;
        DATA: begin
          shreg <= {i, shreg[WIDTH-1:1]};
          cnt   <= cnt + CW'(1);
        end
        PARITY: par_bit <= i;
        default: ;
      endcase
      if (state == STOP) begin
        word       <= shreg;
        valid      <= 1'b1;
        parity_err <= PARITY_EN ? ((^shreg) ^ par_bit) : 1'b0;
        frame_err  <= i;
        // A simultaneous ack consumes the old word, so only an unacked overwrite is flagged
        overrun    <= !ack && (valid || overrun);
      end else if (ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

endmodule
